// File: rtl/mem_bus_master.sv
// Single master on the memory bus: arbitrates fetch vs load/store, runs one transaction at a time.
// Optional build macro MEM_BUS_TIMEOUT_EN adds a WAIT watchdog that aborts with a fault ack.
module mem_bus_master #(
    parameter int RST_SYNC_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_ack,
    output logic [31:0] o_if_data,
    input  logic        i_ls_req,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    input  logic        i_ls_write,
    input  logic [2:0]  i_ls_funct3,
    output logic        o_ls_ack,
    output logic [31:0] o_ls_rdata,
    output logic        o_ls_fault,
    output logic [31:0] o_bus_data,
    output logic [31:0] o_bus_address,
    output logic        o_bus_DV,
    output logic [2:0]  o_bhw,
    output logic        o_write_notread,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_DV,
    output logic [2:0]  o_dbg_state
);

    // Handshakes: a port holds req (and its fields) until the one-cycle ack; the bus side gets a
    // one-cycle o_bus_DV strobe and answers with a level i_bus_DV that stays high until the next strobe.
    typedef enum logic [2:0] {
        S_SYNC  = 3'd0,
        S_IDLE  = 3'd1,
        S_ISSUE = 3'd2,
        S_BLANK = 3'd3,
        S_WAIT  = 3'd4,
        S_RESP  = 3'd5,
        S_FAULT = 3'd6,
        S_TOUT  = 3'd7
    } state_t;

    localparam int SW = $clog2(RST_SYNC_CYCLES + 1);
    localparam logic [SW-1:0] SYNC_LAST = SW'(RST_SYNC_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [SW-1:0] sync_cnt;
    logic        blank_cnt;
    logic        last_grant_ls;
    logic        grant_ls;
    logic        ls_write_q;
    logic [2:0]  funct3_q;
    logic [31:0] rdata_q;
    logic [31:0] bus_address_q;
    logic [31:0] bus_data_q;
    logic [2:0]  bhw_q;
    logic        write_q;
    logic        pick_ls;
    logic        ls_illegal;
    logic        any_req;
    logic [2:0]  ls_bhw;
    logic [31:0] load_ext;

    assign any_req    = i_if_req | i_ls_req;
    // LSU wins a tie unless it was the last port served.
    assign pick_ls    = i_ls_req & (~i_if_req | ~last_grant_ls);
    assign ls_illegal = (i_ls_funct3 == 3'd3) | (i_ls_funct3[2:1] == 2'b11);

    always_comb begin
        case (i_ls_funct3[1:0])
            2'd0:    ls_bhw = 3'b001;
            2'd1:    ls_bhw = 3'b010;
            default: ls_bhw = 3'b100;
        endcase
    end

    always_comb begin
        case (funct3_q)
            3'd0:    load_ext = {{24{rdata_q[7]}}, rdata_q[7:0]};
            3'd4:    load_ext = {24'd0, rdata_q[7:0]};
            3'd1:    load_ext = {{16{rdata_q[15]}}, rdata_q[15:0]};
            3'd5:    load_ext = {16'd0, rdata_q[15:0]};
            default: load_ext = rdata_q;
        endcase
    end

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] wd_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || state != S_WAIT) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    // Without the watchdog the timeout parameter has no effect on the hardware.
    if (TIMEOUT_CYCLES < 1) begin : g_no_watchdog
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_SYNC:  if (sync_cnt == SYNC_LAST) state_nxt = S_IDLE;
            S_IDLE:  if (any_req) state_nxt = (pick_ls && ls_illegal) ? S_FAULT : S_ISSUE;
            S_ISSUE: state_nxt = S_BLANK;
            // i_bus_DV may still be high from the previous transfer, so it is not looked at here.
            S_BLANK: if (blank_cnt) state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_bus_DV) begin
                    state_nxt = S_RESP;
                end
`ifdef MEM_BUS_TIMEOUT_EN
                else if (wd_cnt == WD_LAST) begin
                    state_nxt = S_TOUT;
                end
`endif
            end
            S_RESP:  state_nxt = S_IDLE;
            S_FAULT: state_nxt = S_IDLE;
            S_TOUT:  state_nxt = S_SYNC;
            default: state_nxt = S_SYNC;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_cnt      <= '0;
            blank_cnt     <= 1'b0;
            last_grant_ls <= 1'b0;
            grant_ls      <= 1'b0;
            ls_write_q    <= 1'b0;
            funct3_q      <= 3'd0;
            rdata_q       <= 32'd0;
            bus_address_q <= 32'd0;
            bus_data_q    <= 32'd0;
            bhw_q         <= 3'd0;
            write_q       <= 1'b0;
        end else begin
            sync_cnt  <= (state == S_SYNC) ? sync_cnt + 1'b1 : '0;
            blank_cnt <= (state == S_BLANK) ? ~blank_cnt : 1'b0;
            if (state == S_IDLE && any_req) begin
                grant_ls   <= pick_ls;
                funct3_q   <= i_ls_funct3;
                ls_write_q <= i_ls_write;
                if (!(pick_ls && ls_illegal)) begin
                    bus_address_q <= pick_ls ? i_ls_addr : i_if_addr;
                    bus_data_q    <= pick_ls ? i_ls_wdata : 32'd0;
                    bhw_q         <= pick_ls ? ls_bhw : 3'b100;
                    write_q       <= pick_ls & i_ls_write;
                end
            end
            if (state == S_WAIT && i_bus_DV) begin
                rdata_q <= i_bus_data;
            end
            if (state == S_RESP || state == S_FAULT || state == S_TOUT) begin
                last_grant_ls <= grant_ls;
            end
        end
    end

    always_comb begin
        o_bus_DV   = (state == S_ISSUE);
        o_if_ack   = 1'b0;
        o_if_data  = 32'd0;
        o_ls_ack   = 1'b0;
        o_ls_rdata = 32'd0;
        o_ls_fault = 1'b0;
        case (state)
            S_RESP: begin
                if (grant_ls) begin
                    o_ls_ack   = 1'b1;
                    o_ls_rdata = ls_write_q ? 32'd0 : load_ext;
                end else begin
                    o_if_ack  = 1'b1;
                    o_if_data = rdata_q;
                end
            end
            S_FAULT: begin
                o_ls_ack   = 1'b1;
                o_ls_fault = 1'b1;
            end
            S_TOUT: begin
                if (grant_ls) begin
                    o_ls_ack   = 1'b1;
                    o_ls_fault = 1'b1;
                end else begin
                    o_if_ack = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign o_bus_address   = bus_address_q;
    assign o_bus_data      = bus_data_q;
    assign o_bhw           = bhw_q;
    assign o_write_notread = write_q;
    assign o_dbg_state     = state;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: directed port drivers, a memory responder, and a queue scoreboard.
module tb_mem_bus_master;
    localparam int RST_SYNC = 16;
    localparam int TO       = 4096;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_ack;
    logic [31:0] o_if_data;
    logic        i_ls_req;
    logic [31:0] i_ls_addr;
    logic [31:0] i_ls_wdata;
    logic        i_ls_write;
    logic [2:0]  i_ls_funct3;
    logic        o_ls_ack;
    logic [31:0] o_ls_rdata;
    logic        o_ls_fault;
    logic [31:0] o_bus_data;
    logic [31:0] o_bus_address;
    logic        o_bus_DV;
    logic [2:0]  o_bhw;
    logic        o_write_notread;
    logic [31:0] i_bus_data;
    logic        i_bus_DV;
    logic [2:0]  o_dbg_state;

    mem_bus_master #(.RST_SYNC_CYCLES(RST_SYNC), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_ack(o_if_ack), .o_if_data(o_if_data),
        .i_ls_req(i_ls_req), .i_ls_addr(i_ls_addr), .i_ls_wdata(i_ls_wdata), .i_ls_write(i_ls_write),
        .i_ls_funct3(i_ls_funct3), .o_ls_ack(o_ls_ack), .o_ls_rdata(o_ls_rdata), .o_ls_fault(o_ls_fault),
        .o_bus_data(o_bus_data), .o_bus_address(o_bus_address), .o_bus_DV(o_bus_DV), .o_bhw(o_bhw),
        .o_write_notread(o_write_notread), .i_bus_data(i_bus_data), .i_bus_DV(i_bus_DV),
        .o_dbg_state(o_dbg_state)
    );

    // clock / cycle counter
    always #5 i_clk = ~i_clk;
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // ack entry: {kind[1:0] (0 normal, 1 illegal, 2 timeout), is_ls, fault, data[31:0]}
    logic [35:0] exp_q[$];
    // bus entry: {write, bhw[2:0], addr[31:0], wdata[31:0]}
    logic [67:0] bus_q[$];
    logic [31:0] mem_q[$];

    int mem_hold    = 1;
    int mem_lat     = 3;
    bit mem_respond = 1'b1;
    int rise_cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // model helpers
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] d);
        int unsigned b;
        int unsigned h;
        b = d % 256;
        h = d % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    function automatic logic [2:0] model_bhw(input logic [2:0] f3);
        int bytes;
        bytes = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        return 3'(bytes);
    endfunction

    function automatic bit model_illegal(input logic [2:0] f3);
        return (f3 == 3) || (f3 == 6) || (f3 == 7);
    endfunction

    task automatic exp_fetch(input logic [31:0] addr, input logic [31:0] mdata);
        bus_q.push_back({1'b0, 3'b100, addr, 32'h0});
        mem_q.push_back(mdata);
        exp_q.push_back({2'd0, 1'b0, 1'b0, mdata});
    endtask

    task automatic exp_ls(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                          input logic [2:0] f3, input logic [31:0] mdata);
        if (model_illegal(f3)) begin
            exp_q.push_back({2'd1, 1'b1, 1'b1, 32'h0});
        end else begin
            bus_q.push_back({wr, model_bhw(f3), addr, wdata});
            mem_q.push_back(mdata);
            exp_q.push_back({2'd0, 1'b1, 1'b0, wr ? 32'h0 : model_load(f3, mdata)});
        end
    endtask

    // driver tasks (start at #1 after a posedge; return at #1 after the posedge following the ack)
    task automatic if_txn(input logic [31:0] addr, input int budget,
                          output logic [31:0] data, output int lat);
        int start;
        int n;
        start = cyc;
        n = 0;
        data = 32'h0;
        lat = -1;
        i_if_req = 1'b1;
        i_if_addr = addr;
        while (1) begin
            @(negedge i_clk);
            if (o_if_ack) begin
                data = o_if_data;
                lat = cyc - start;
                break;
            end
            n++;
            if (n > budget) begin
                n_tests++;
                n_fail++;
                $display("FAIL if_ack_timeout: no fetch ack within %0d cycles, addr 0x%08h", budget, addr);
                break;
            end
        end
        @(posedge i_clk);
        #1;
        i_if_req = 1'b0;
    endtask

    task automatic ls_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                          input logic [2:0] f3, input int budget,
                          output logic [31:0] data, output logic fault, output int lat);
        int start;
        int n;
        start = cyc;
        n = 0;
        data = 32'h0;
        fault = 1'b0;
        lat = -1;
        i_ls_req = 1'b1;
        i_ls_addr = addr;
        i_ls_wdata = wdata;
        i_ls_write = wr;
        i_ls_funct3 = f3;
        while (1) begin
            @(negedge i_clk);
            if (o_ls_ack) begin
                data = o_ls_rdata;
                fault = o_ls_fault;
                lat = cyc - start;
                break;
            end
            n++;
            if (n > budget) begin
                n_tests++;
                n_fail++;
                $display("FAIL ls_ack_timeout: no ls ack within %0d cycles, addr 0x%08h", budget, addr);
                break;
            end
        end
        @(posedge i_clk);
        #1;
        i_ls_req = 1'b0;
    endtask

    // memory responder: level DV held for mem_hold cycles after a strobe, then low, then re-raised
    initial begin
        i_bus_DV = 1'b0;
        i_bus_data = 32'h0;
        forever begin
            @(posedge i_clk);
            #1;
            if (o_bus_DV && !i_rst) begin
                repeat (mem_hold) begin
                    @(posedge i_clk);
                    #1;
                end
                i_bus_DV = 1'b0;
                if (mem_respond) begin
                    repeat (mem_lat) begin
                        @(posedge i_clk);
                        #1;
                    end
                    i_bus_data = (mem_q.size() > 0) ? mem_q.pop_front() : 32'hBAD0_BAD0;
                    i_bus_DV = 1'b1;
                    rise_cyc = cyc;
                end
            end
        end
    end

    // scoreboard / compare process
    initial begin
        logic [67:0] be;
        logic [35:0] ae;
        int last_strobe;
        int exp_cyc;
        bit prev_dv;
        bit strobe_seen;
        last_strobe = 0;
        prev_dv = 1'b0;
        strobe_seen = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                prev_dv = 1'b0;
                strobe_seen = 1'b0;
            end else begin
                if (o_bus_DV) begin
                    if (prev_dv) chk("strobe_one_cycle", 32'(prev_dv), 32'd0);
                    if (bus_q.size() == 0) begin
                        chk("unexpected_strobe", {o_bus_address}, 32'hFFFF_FFFF);
                    end else begin
                        be = bus_q.pop_front();
                        chk("bus_address", o_bus_address, be[63:32]);
                        chk("bus_bhw", 32'(o_bhw), 32'(be[66:64]));
                        chk("bus_write", 32'(o_write_notread), 32'(be[67]));
                        if (be[67]) chk("bus_wdata", o_bus_data, be[31:0]);
                    end
                    last_strobe = cyc;
                    strobe_seen = 1'b1;
                end
                prev_dv = o_bus_DV;
                if (o_if_ack && o_ls_ack) chk("one_ack_per_cycle", 32'd2, 32'd1);
                if (o_ls_fault && !o_ls_ack) chk("fault_without_ack", 32'd1, 32'd0);
                if (o_if_ack || o_ls_ack) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", 32'(o_ls_ack), 32'hFFFF_FFFF);
                    end else begin
                        ae = exp_q.pop_front();
                        chk("ack_port", 32'(o_ls_ack), 32'(ae[33]));
                        chk("ack_data", ae[33] ? o_ls_rdata : o_if_data, ae[31:0]);
                        chk("ack_fault", 32'(o_ls_fault), 32'(ae[32]));
                        if (ae[35:34] == 2'd0) begin
                            exp_cyc = ((last_strobe + 3 > rise_cyc) ? last_strobe + 3 : rise_cyc) + 1;
                            chk("ack_cycle", cyc, exp_cyc);
                        end else if (ae[35:34] == 2'd1) begin
                            chk("illegal_no_strobe", 32'(strobe_seen), 32'd0);
                        end else begin
                            chk("timeout_cycle", cyc, last_strobe + 3 + TO);
                        end
                    end
                    strobe_seen = 1'b0;
                end
            end
        end
    end

    // main stimulus
    initial begin
        logic [31:0] d;
        logic [31:0] d_l0, d_l1, d_f0, d_f1;
        logic        f, f_l0, f_l1;
        int          lat, lat_l0, lat_l1, lat_f0, lat_f1;
        int          rst_cyc;
        int          n;
        logic [2:0]  load_f3[5];
        logic [31:0] load_exp[5];
        logic [2:0]  bad_f3[3];

        load_f3  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        load_exp = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_80F0, 32'h0000_80F0, 32'h0000_80F0};
        bad_f3   = '{3'd3, 3'd6, 3'd7};

        i_rst = 1'b1;
        i_if_req = 1'b0;
        i_if_addr = 32'h0;
        i_ls_req = 1'b0;
        i_ls_addr = 32'h0;
        i_ls_wdata = 32'h0;
        i_ls_write = 1'b0;
        i_ls_funct3 = 3'd0;

        // reset values
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset_ctrl", 32'({o_if_ack, o_ls_ack, o_ls_fault, o_bus_DV, o_write_notread, o_bhw}), 32'd0);
        chk("reset_addr", o_bus_address, 32'd0);
        chk("reset_wdata", o_bus_data, 32'd0);
        chk("reset_rdata", o_if_data | o_ls_rdata, 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        repeat (RST_SYNC + 4) @(posedge i_clk);
        #1;

        // fetch read
        mem_hold = 1;
        mem_lat = 3;
        exp_fetch(32'h0000_0100, 32'hDEAD_BEEF);
        if_txn(32'h0000_0100, 100, d, lat);
        chk("fetch_data", d, 32'hDEAD_BEEF);
        chk("fetch_latency", 32'(lat), 32'd6);

        // stale DV (still high from the fetch) with both ports requesting
        mem_hold = 3;
        mem_lat = 2;
        exp_ls(32'h0000_0400, 32'h0, 1'b0, 3'd2, 32'h1111_1111);
        exp_fetch(32'h0000_0500, 32'h2222_2222);
        exp_ls(32'h0000_0404, 32'h0, 1'b0, 3'd2, 32'h3333_3333);
        exp_fetch(32'h0000_0504, 32'h4444_4444);
        fork
            begin
                ls_txn(32'h0000_0400, 32'h0, 1'b0, 3'd2, 200, d_l0, f_l0, lat_l0);
                ls_txn(32'h0000_0404, 32'h0, 1'b0, 3'd2, 200, d_l1, f_l1, lat_l1);
            end
            begin
                if_txn(32'h0000_0500, 200, d_f0, lat_f0);
                if_txn(32'h0000_0504, 200, d_f1, lat_f1);
            end
        join
        chk("arb_ls0_data", d_l0, 32'h1111_1111);
        chk("arb_if0_data", d_f0, 32'h2222_2222);
        chk("stale_first_latency", 32'(lat_l0), 32'd7);

        // signed / unsigned loads
        mem_hold = 1;
        for (int i = 0; i < 5; i++) begin
            mem_lat = i + 1;
            exp_ls(32'h0000_0200 + 32'(i), 32'h0, 1'b0, load_f3[i], 32'h0000_80F0);
            ls_txn(32'h0000_0200 + 32'(i), 32'h0, 1'b0, load_f3[i], 100, d, f, lat);
            chk("load_ext", d, load_exp[i]);
        end

        // store half
        mem_lat = 2;
        exp_ls(32'h0000_0300, 32'h1234_ABCD, 1'b1, 3'd1, 32'h5A5A_5A5A);
        ls_txn(32'h0000_0300, 32'h1234_ABCD, 1'b1, 3'd1, 100, d, f, lat);
        chk("store_rdata", d, 32'h0);
        chk("store_fault", 32'(f), 32'd0);

        // illegal funct3
        for (int i = 0; i < 3; i++) begin
            exp_ls(32'h0000_0310, 32'h0, 1'b0, bad_f3[i], 32'h0);
            ls_txn(32'h0000_0310, 32'h0, 1'b0, bad_f3[i], 20, d, f, lat);
            chk("illegal_fault", 32'(f), 32'd1);
            chk("illegal_rdata", d, 32'h0);
            chk("illegal_latency", 32'(lat), 32'd1);
        end

        // reset while WAITing on a memory that never answers
        mem_respond = 1'b0;
        mem_hold = 1;
        bus_q.push_back({1'b0, 3'b100, 32'h0000_0600, 32'h0});
        i_if_addr = 32'h0000_0600;
        i_if_req = 1'b1;
        n = 0;
        while (1) begin
            @(negedge i_clk);
            if (o_bus_DV) break;
            n++;
            if (n > 20) begin
                chk("rst_test_strobe", 32'd0, 32'd1);
                break;
            end
        end
        repeat (6) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        rst_cyc = cyc;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("midrst_ctrl", 32'({o_if_ack, o_ls_ack, o_ls_fault, o_bus_DV, o_write_notread, o_bhw}), 32'd0);
        chk("midrst_addr", o_bus_address, 32'd0);
        mem_respond = 1'b1;
        mem_lat = 3;
        exp_fetch(32'h0000_0600, 32'hCAFE_F00D);
        n = 0;
        while (!o_bus_DV && n <= 60) begin
            @(negedge i_clk);
            n++;
        end
        chk("sync_gap_min", 32'((cyc - rst_cyc) >= RST_SYNC), 32'd1);
        chk("sync_gap_max", 32'((cyc - rst_cyc) <= RST_SYNC + 1), 32'd1);
        if_txn(32'h0000_0600, 100, d, lat);
        chk("post_rst_fetch", d, 32'hCAFE_F00D);

`ifdef MEM_BUS_TIMEOUT_EN
        // memory that never responds
        mem_respond = 1'b0;
        bus_q.push_back({1'b0, 3'b100, 32'h0000_0700, 32'h0});
        exp_q.push_back({2'd2, 1'b1, 1'b1, 32'h0});
        ls_txn(32'h0000_0700, 32'h0, 1'b0, 3'd2, TO + 50, d, f, lat);
        chk("timeout_fault", 32'(f), 32'd1);
        chk("timeout_rdata", d, 32'h0);
        chk("timeout_latency", 32'(lat), 32'(TO + 4));
`endif

        repeat (4) @(posedge i_clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Upstream stage of the memory subsystem; the only master driving the memory bus (bus_data/address/DV/bhw/write_notread).
- Arbitrates between the CPU instruction-fetch port and the load/store port. Issues one bus transaction at a time and handles the level-style completion DV.
- Returns fetched words, and sign/zero-extended load data, as one-cycle acks.

Parameters:
- RST_SYNC_CYCLES, 16, quiet cycles after reset release before the first issue, so the memory side drains any in-flight transfer.
- TIMEOUT_CYCLES, 4096, watchdog limit in WAIT; used only with MEM_BUS_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock; all logic on posedge
- i_rst  in  1  synchronous, active-high reset
- i_if_req  in  1  fetch request; level, held until o_if_ack
- i_if_addr  in  32  fetch address; always a word read
- o_if_ack  out  1  one-cycle pulse; o_if_data valid this cycle
- o_if_data  out  32  fetched word
- i_ls_req  in  1  load/store request; level, held until o_ls_ack
- i_ls_addr  in  32  byte address
- i_ls_wdata  in  32  store data, right-aligned
- i_ls_write  in  1  1 = store, 0 = load
- i_ls_funct3  in  3  RV32 width code: 0=B, 1=H, 2=W, 4=BU, 5=HU
- o_ls_ack  out  1  one-cycle completion pulse
- o_ls_rdata  out  32  extended load data (0 on stores)
- o_ls_fault  out  1  pulses with o_ls_ack on an illegal funct3 or a timeout
- o_bus_data  out  32  write data to memory
- o_bus_address  out  32  start byte address
- o_bus_DV  out  1  one-cycle request strobe
- o_bhw  out  3  byte count: 3'b100 word, 3'b010 half, 3'b001 byte
- o_write_notread  out  1  1 = write
- i_bus_data  in  32  read data; byte at address N in [7:0], N+1 in [15:8]
- i_bus_DV  in  1  completion; level-high from completion until the next strobe is accepted

Behaviour:
- Reset: every output = 0; state SYNC; counters cleared.
- SYNC: counts RST_SYNC_CYCLES, then goes to IDLE. A request arriving during SYNC waits.
- IDLE, grant selection:
  - Only one port requesting: that port is granted.
  - Both requesting: round-robin via a last_grant flag (reset value = fetch, so LSU wins the first tie).
- IDLE, illegal funct3 (3, 6, 7) on an LSU grant:
  - No bus cycle is issued.
  - Next cycle: o_ls_ack=1, o_ls_fault=1, o_ls_rdata=0; return to IDLE.
- IDLE, legal grant:
  - Latch the request into o_bus_address, o_bhw, o_write_notread, o_bus_data.
  - Store data is passed unshifted; the memory consumes the low bytes.
  - Assert o_bus_DV for exactly one cycle (ISSUE), then go to BLANK.
- BLANK:
  - Lasts 2 cycles; i_bus_DV is ignored throughout, because it may still be high from the previous transfer.
  - Outputs stay latched; then go to WAIT.
- WAIT: the first cycle with i_bus_DV=1 captures i_bus_data and goes to RESP.
- RESP (one cycle):
  - Pulse the granted port's ack with its data.
  - Load extension: B → sign-extend [7:0]; BU → zero-extend [7:0]; H → sign-extend [15:0]; HU → zero-extend [15:0]; W → as is.
  - Update last_grant; go to IDLE.
  - A new request may be granted in the cycle after RESP.
- Latency: a legal access with zero memory wait acks no earlier than 5 cycles after the grant (ISSUE + 2 BLANK + ≥1 WAIT + RESP).
- Misalignment: no checks; the address is passed as is and the memory fetches sequential bytes.
- Request stability: a requester may not drop req before ack. If it does, the transaction still completes and the ack is still pulsed.
- Reset mid-transaction:
  - Immediate return to SYNC; all outputs 0; no ack is generated.
  - The full RST_SYNC_CYCLES delay reapplies.
- Only one ack per cycle, across both ports.

Optional Feature:
- Macro: MEM_BUS_TIMEOUT_EN.
- Enabled:
  - A counter runs in WAIT. When it reaches TIMEOUT_CYCLES without i_bus_DV, the block pulses the granted port's ack with data 0, plus o_ls_fault if the grant was LSU.
  - It then goes to SYNC, so the memory side can drain.
- Disabled:
  - WAIT is unbounded.
  - o_ls_fault asserts only for an illegal funct3; no counter logic is synthesized.

Test Plan:
- Fetch read: i_if_addr=0x00000100, memory returns 0xDEADBEEF after 3 cycles → exactly one bus strobe with o_bhw=3'b100 and o_write_notread=0; o_if_ack pulse with o_if_data=0xDEADBEEF.
- Signed and unsigned loads, memory returns 0x000080F0:
  - funct3=0 (LB) → o_ls_rdata=0xFFFFFFF0
  - funct3=4 (LBU) → 0x000000F0
  - funct3=1 (LH) → 0xFFFF80F0
  - funct3=5 (HU) → 0x000080F0
- Store half: i_ls_wdata=0x1234ABCD, funct3=1, write=1 → o_bhw=3'b010, o_bus_data=0x1234ABCD, o_write_notread=1; o_ls_ack with o_ls_rdata=0.
- Stale DV and arbitration:
  - Hold i_bus_DV high from the previous transfer while both ports request.
  - The stale DV is not taken as completion: no ack before the memory drops and re-raises DV.
  - Grants alternate LSU, fetch, LSU across 3 back-to-back transactions.
- Illegal funct3=3 → no o_bus_DV; o_ls_ack and o_ls_fault next cycle; rdata=0.
- Reset mid-WAIT, then (MEM_BUS_TIMEOUT_EN build) a memory that never responds:
  - Reset mid-WAIT → no ack; the next strobe appears ≥16 cycles after reset release.
  - Never-responding memory → ack and fault after exactly TIMEOUT_CYCLES in WAIT.
